// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the EX stage and the mul/div sequencer.
interface muldiv_sequencer_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [3:0]       sel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;
   logic             div_zero;

   modport master (
      output start, sel, op_a, op_b, flush,
      input  busy, stall, done, res_lo, res_hi, div_zero
   );

   modport slave (
      input  start, sel, op_a, op_b, flush,
      output busy, stall, done, res_lo, res_hi, div_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed shift-add multiply / restoring divide with pipeline stall request.
// Results appear as a {hi, lo} pair with a one-cycle done pulse.
module muldiv_sequencer #(
   parameter int unsigned WIDTH   = 16,
   parameter logic [3:0]  SEL_MUL = 4'b0010,
   parameter logic [3:0]  SEL_DIV = 4'b0011
) (
   input logic                clk,
   input logic                rst_n,
   muldiv_sequencer_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] hi, lo;
   logic [WIDTH-1:0] hi_n, lo_n;

   logic             accept;
   logic             sel_div;
   logic             div0;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sum, shifted, diff;
   logic [PW-1:0]    prod, prod_s;
   logic [WIDTH-1:0] quo_s, rem_s;

   // Launch qualification; flush wins over a same-cycle start.
   always_comb begin
      sel_div = (bus.sel == SEL_DIV);
      accept  = bus.start && (bus.sel == SEL_MUL || sel_div) &&
                (state == IDLE) && !bus.flush;
      div0    = sel_div && (bus.op_b == '0);
      a_mag   = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
      b_mag   = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
   end

   assign bus.stall = bus.busy | accept;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = div0 ? DONE : CALC;
         CALC: if (cnt == '0) state_nxt = SIGN;
         SIGN: state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_nxt;
         bus.busy <= (state_nxt == CALC) || (state_nxt == SIGN);
         bus.done <= (state_nxt == DONE);
      end
   end

   // One iteration: mul shifts {carry, hi, lo} right; div shifts the quotient into the remainder.
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {hi, lo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      hi_n    = '0;
      lo_n    = '0;
      if (is_div) begin
         if (!diff[WIDTH]) begin
            hi_n = diff[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = sum[WIDTH:1];
         lo_n = {sum[0], lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod   = {hi, lo};
      prod_s = sign_q ? -prod : prod;
      quo_s  = sign_q ? -lo : lo;
      rem_s  = sign_r ? -hi : hi;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         is_div       <= 1'b0;
         sign_q       <= 1'b0;
         sign_r       <= 1'b0;
         opnd         <= '0;
         hi           <= '0;
         lo           <= '0;
         bus.res_lo   <= '0;
         bus.res_hi   <= '0;
         bus.div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               is_div <= sel_div;
               sign_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
               sign_r <= bus.op_a[WIDTH-1];
               cnt    <= CW'(WIDTH - 1);
               hi     <= '0;
               lo     <= sel_div ? a_mag : b_mag;
               opnd   <= sel_div ? b_mag : a_mag;
               if (div0) begin
                  bus.res_lo   <= '1;
                  bus.res_hi   <= bus.op_a;
                  bus.div_zero <= 1'b1;
               end
            end
            CALC: begin
               hi <= hi_n;
               lo <= lo_n;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            SIGN: if (state_nxt == DONE) begin
               bus.res_lo   <= is_div ? quo_s : prod_s[WIDTH-1:0];
               bus.res_hi   <= is_div ? rem_s : prod_s[PW-1:WIDTH];
               bus.div_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed mul/div vectors, ignored starts, flush and reset aborts.
module tb_muldiv_sequencer;
   localparam int unsigned WIDTH   = 16;
   localparam logic [3:0]  SEL_MUL = 4'b0010;
   localparam logic [3:0]  SEL_DIV = 4'b0011;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic        dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();
   muldiv_sequencer #(.WIDTH(WIDTH), .SEL_MUL(SEL_MUL), .SEL_DIV(SEL_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] last_lo = '0;
   logic [15:0] last_hi = '0;
   logic        last_dz = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got lo=%h hi=%h dz=%b expected no done",
                     bus.res_lo, bus.res_hi, bus.div_zero);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (bus.res_lo !== e.lo || bus.res_hi !== e.hi || bus.div_zero !== e.dz) begin
               errors++;
               $display("FAIL result: got lo=%h hi=%h dz=%b expected lo=%h hi=%h dz=%b",
                        bus.res_lo, bus.res_hi, bus.div_zero, e.lo, e.hi, e.dz);
            end
         end
      end
   end

   task automatic run_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input logic [15:0] elo, input logic [15:0] ehi,
                         input logic edz, input int inject_at);
      int cyc;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.sel = sel; bus.op_a = a; bus.op_b = b;
      #1 check("stall_on_accept", 32'(bus.stall), 32'd1);
      q.push_back('{elo, ehi, edz});
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            bus.start = 1'b0;
            check("busy_after_accept", 32'(bus.busy), 32'(lat != 1));
         end
         if (cyc == inject_at) begin
            bus.start = 1'b1; bus.sel = SEL_DIV; bus.op_a = 16'h0064; bus.op_b = 16'h0003;
         end else if (cyc == inject_at + 1) begin
            bus.start = 1'b0;
         end
      end while (bus.done !== 1'b1 && cyc < 40);
      check("latency", 32'(cyc), 32'(lat));
      check("stall_in_done", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      last_lo = elo; last_hi = ehi; last_dz = edz;
   endtask

   task automatic abort_op(input bit use_rst);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.sel = SEL_MUL; bus.op_a = 16'h0003; bus.op_b = 16'h0005;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.start = 1'b0;
      end
      if (use_rst) begin
         rst_n = 1'b0;
         #1;
         check("rst_busy", 32'(bus.busy), 32'd0);
         check("rst_done", 32'(bus.done), 32'd0);
         check("rst_res_lo", 32'(bus.res_lo), 32'd0);
         check("rst_res_hi", 32'(bus.res_hi), 32'd0);
         check("rst_div_zero", 32'(bus.div_zero), 32'd0);
         @(posedge clk); #1;
         rst_n = 1'b1;
         last_lo = '0; last_hi = '0; last_dz = 1'b0;
      end else begin
         bus.flush = 1'b1;
         @(posedge clk); #1;
         bus.flush = 1'b0;
         check("flush_busy", 32'(bus.busy), 32'd0);
         check("flush_res_lo", 32'(bus.res_lo), 32'(last_lo));
         check("flush_res_hi", 32'(bus.res_hi), 32'(last_hi));
         check("flush_div_zero", 32'(bus.div_zero), 32'(last_dz));
      end
      repeat (25) @(posedge clk);
      #1 check("abort_idle_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.sel = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
      #12;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_stall", 32'(bus.stall), 32'd0);
      check("reset_res_lo", 32'(bus.res_lo), 32'd0);
      check("reset_res_hi", 32'(bus.res_hi), 32'd0);
      check("reset_div_zero", 32'(bus.div_zero), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op(SEL_MUL, 16'h0007, 16'hFFFD, 18, 16'hFFEB, 16'hFFFF, 1'b0, -10);
      run_op(SEL_DIV, 16'hFFF9, 16'h0002, 18, 16'hFFFD, 16'hFFFF, 1'b0, -10);
      run_op(SEL_DIV, 16'h0005, 16'h0000, 1,  16'hFFFF, 16'h0005, 1'b1, -10);
      run_op(SEL_DIV, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000, 1'b0, -10);
      run_op(SEL_MUL, 16'h8000, 16'h8000, 18, 16'h0000, 16'h4000, 1'b0, -10);
      run_op(SEL_MUL, 16'h7FFF, 16'h8000, 18, 16'h8000, 16'hC000, 1'b0, -10);
      run_op(SEL_MUL, 16'hFFFF, 16'hFFFF, 18, 16'h0001, 16'h0000, 1'b0, -10);
      run_op(SEL_DIV, 16'h0064, 16'hFFF9, 18, 16'hFFF2, 16'h0002, 1'b0, -10);
      run_op(SEL_DIV, 16'hFF9C, 16'h0007, 18, 16'hFFF2, 16'hFFFE, 1'b0, -10);

      // Non-mul/div select and flush-with-start must both be ignored.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.sel = 4'b0000; bus.op_a = 16'h0009; bus.op_b = 16'h0002;
      #1 check("ignored_sel_stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("ignored_sel_busy", 32'(bus.busy), 32'd0);
      bus.start = 1'b1; bus.sel = SEL_MUL; bus.flush = 1'b1;
      #1 check("flush_prio_stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush_prio_busy", 32'(bus.busy), 32'd0);
      repeat (22) @(posedge clk);

      run_op(SEL_MUL, 16'h0003, 16'h0004, 18, 16'h000C, 16'h0000, 1'b0, 5);
      repeat (22) @(posedge clk);

      abort_op(1'b0);
      abort_op(1'b1);
      run_op(SEL_MUL, 16'h0002, 16'h0003, 18, 16'h0006, 16'h0000, 1'b0, -10);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
